// File: rtl/uart_cmd_wrapper.sv
// Assembles 16-bit commands from pairs of UART bytes (high first) and forwards response bytes to the transmitter.
// Optional inter-byte timeout compiled in with `define UART_CMD_WRAPPER_TIMEOUT_EN.
module uart_cmd_wrapper #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic [1:0]  dbg_state
);

  // Handshakes: rx_rdy/clr_rx_rdy - a byte is consumed exactly once by a one-cycle clr_rx_rdy pulse;
  // cmd_rdy/clr_cmd_rdy - cmd is held until acknowledged; send_resp/trmt and tx_done/resp_sent are pulses.

  typedef enum logic {IDLE = 1'b0, WAIT_LO = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_t;

  rx_state_t  rx_state, rx_next;
  tx_state_t  tx_state, tx_next;
  logic [7:0] hi_byte;
  logic       byte_ok;
  logic       take_hi;
  logic       take_lo;
  logic       cmd_pend;
  logic       timed_out;
  logic       start_tx;
  logic       finish_tx;

  // The receiver still shows the consumed byte while our pulse is high, so never take it twice.
  assign byte_ok = rx_rdy & ~clr_rx_rdy;

`ifdef UART_CMD_WRAPPER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (rx_state == WAIT_LO && rx_next == WAIT_LO) begin
      to_cnt <= to_cnt + CW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timed_out = (rx_state == WAIT_LO) && !byte_ok && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout the parameter has no effect and WAIT_LO waits indefinitely.
  assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

  // ---------------- receive FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (byte_ok) rx_next = WAIT_LO;
      WAIT_LO: if (byte_ok || timed_out) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_comb begin
    take_hi = (rx_state == IDLE) && byte_ok;
    take_lo = (rx_state == WAIT_LO) && byte_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte    <= 8'h00;
      cmd        <= 16'h0000;
      cmd_pend   <= 1'b0;
      cmd_rdy    <= 1'b0;
      clr_rx_rdy <= 1'b0;
    end else begin
      clr_rx_rdy <= take_hi | take_lo;
      cmd_pend   <= take_lo;
      if (take_hi) hi_byte <= rx_data;
      if (take_lo) cmd <= {hi_byte, rx_data};
      // A completing command wins over a simultaneous acknowledge.
      if (cmd_pend) begin
        cmd_rdy <= 1'b1;
      end else if (take_hi || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  // ---------------- transmit FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (send_resp) tx_next = TX_BUSY;
      TX_BUSY: if (tx_done) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    start_tx  = (tx_state == TX_IDLE) && send_resp;
    finish_tx = (tx_state == TX_BUSY) && tx_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      trmt      <= start_tx;
      resp_sent <= finish_tx;
      if (start_tx) tx_data <= resp;
    end
  end

  assign dbg_state = {tx_state == TX_BUSY, rx_state == WAIT_LO};

endmodule
